// File: rtl/rm_wstrb_gen_if.sv
// Command, aligner-drain and bus-beat signal bundle for rm_wstrb_gen.
// slave = generator side, master = surrounding logic / testbench side.
interface rm_wstrb_gen_if #(
   parameter int EW   = 8,
   parameter int BEC  = 16,
   parameter int LENW = 16
);
   localparam int OFSW = (BEC == 1) ? 1 : $clog2(BEC);
   localparam int BECW = $clog2(BEC + 1);

   // Every handshake is strict valid/ready: a transfer happens on a rising
   // clk edge where both are high; a valid side holds its payload until then.
   logic              cmd_val;
   logic              cmd_rdy;
   logic [OFSW-1:0]   cmd_ofs;
   logic [LENW-1:0]   cmd_len;
   logic              src_val;
   logic              src_rdy;
   logic [BEC*EW-1:0] src_b;
   logic [OFSW-1:0]   src_ofs;
   logic [BECW-1:0]   src_ec;
   logic              bus_val;
   logic              bus_rdy;
   logic [BEC*EW-1:0] bus_data;
   logic [BEC-1:0]    bus_strb;
   logic              bus_last;

   modport slave (
      input  cmd_val, cmd_ofs, cmd_len, src_val, src_b, bus_rdy,
      output cmd_rdy, src_rdy, src_ofs, src_ec, bus_val, bus_data, bus_strb, bus_last
   );

   modport master (
      output cmd_val, cmd_ofs, cmd_len, src_val, src_b, bus_rdy,
      input  cmd_rdy, src_rdy, src_ofs, src_ec, bus_val, bus_data, bus_strb, bus_last
   );
endinterface

// File: rtl/rm_wstrb_gen.sv
// Write-beat generator draining the element realignment FIFO into strobed bus beats.
// Optional macro RM_WSTRB_ZERO_FILL_EN: zero data lanes whose strobe is low.
module rm_wstrb_gen #(
   parameter int EW   = 8,
   parameter int BEC  = 16,
   parameter int LENW = 16
) (
   input  logic                clk,
   input  logic                rst,
   rm_wstrb_gen_if.slave       io,
   output logic                busy,
   output logic                dbg_state
);
   localparam int OFSW = (BEC == 1) ? 1 : $clog2(BEC);
   localparam int BECW = $clog2(BEC + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [OFSW-1:0]   lane;
   logic [LENW-1:0]   rem;
   logic              bus_val_q;
   logic [BEC*EW-1:0] bus_data_q;
   logic [BEC-1:0]    bus_strb_q;
   logic              bus_last_q;

   logic [LENW-1:0]   room;
   logic [LENW-1:0]   ec_l;
   logic [BECW-1:0]   ec;
   logic [BECW:0]     lo;
   logic [BECW:0]     hi;
   logic [BEC-1:0]    mask;
   logic [BEC*EW-1:0] data_next;
   logic              src_rdy_c;
   logic              load;
   logic              final_beat;
   logic              ofs_ok;

   // Beat size depends only on registered lane/rem, never on src_val.
   always_comb begin
      room = LENW'(BEC) - LENW'(lane);
      ec_l = (rem < room) ? rem : room;
      ec   = ec_l[BECW-1:0];
   end

   always_comb begin
      mask = '0;
      lo   = (BECW+1)'(lane);
      hi   = lo + (BECW+1)'(ec);
      for (int i = 0; i < BEC; i++) begin
         mask[i] = ((BECW+1)'(i) >= lo) && ((BECW+1)'(i) < hi);
      end
   end

   always_comb begin
      data_next = io.src_b;
`ifdef RM_WSTRB_ZERO_FILL_EN
      for (int i = 0; i < BEC; i++) begin
         if (!mask[i]) data_next[i*EW +: EW] = '0;
      end
`endif
   end

   assign src_rdy_c  = (state == RUN) && (!bus_val_q || io.bus_rdy);
   assign load       = io.src_val && src_rdy_c;
   assign final_beat = (rem == ec_l);
   assign ofs_ok     = (BECW+1)'(io.cmd_ofs) < (BECW+1)'(BEC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lane       <= '0;
         rem        <= '0;
         bus_val_q  <= 1'b0;
         bus_data_q <= '0;
         bus_strb_q <= '0;
         bus_last_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A zero-length command is consumed here without producing beats.
               if (io.cmd_val && io.cmd_len != '0) begin
                  state <= RUN;
                  lane  <= ofs_ok ? io.cmd_ofs : '0;
                  rem   <= io.cmd_len;
               end
            end
            RUN: begin
               if (load) begin
                  rem  <= rem - ec_l;
                  lane <= '0;
                  if (final_beat) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (load) begin
            bus_val_q  <= 1'b1;
            bus_data_q <= data_next;
            bus_strb_q <= mask;
            bus_last_q <= final_beat;
         end else if (bus_val_q && io.bus_rdy) begin
            bus_val_q <= 1'b0;
         end
      end
   end

   assign io.cmd_rdy  = (state == IDLE);
   assign io.src_rdy  = src_rdy_c;
   assign io.src_ofs  = (state == RUN) ? lane : '0;
   assign io.src_ec   = (state == RUN) ? ec : '0;
   assign io.bus_val  = bus_val_q;
   assign io.bus_data = bus_data_q;
   assign io.bus_strb = bus_strb_q;
   assign io.bus_last = bus_last_q;
   assign busy        = (state != IDLE) || bus_val_q;
   assign dbg_state   = state;
endmodule

// File: doc/rm_wstrb_gen.md
# rm_wstrb_gen

Write-beat generator at the drain side of the element realignment FIFO: accepts a transfer command (start lane, element count), pulls lane-positioned element vectors from the aligner, and emits bus write beats with per-lane strobes and a last flag. It drives the aligner's output-side controls (output offset, element count) and consumes its output handshake, so the aligner runs unmodified behind it. One beat per cycle sustained; one registered output stage.

## Interface
- EW, 8: element width in bits
- BEC, 16: elements (lanes) per bus beat
- LENW, 16: width of transfer length in elements
- Derived: OFSW = (BEC==1) ? 1 : $clog2(BEC); BECW = $clog2(BEC+1)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_ofs  in  OFSW  bus lane of first element
- cmd_len  in  LENW  total elements in transfer
- src_val  in  1  aligner output valid (aligner holds >= src_ec elements)
- src_rdy  out  1  pop aligner
- src_b  in  BEC*EW  aligner output vector, lane-positioned
- src_ofs  out  OFSW  requested lane of first element this beat (aligner output offset)
- src_ec  out  BECW  elements popped this beat (aligner output count)
- bus_val  out  1  beat valid
- bus_rdy  in  1  beat accepted
- bus_data  out  BEC*EW  beat data
- bus_strb  out  BEC  lane strobe
- bus_last  out  1  final beat of transfer
- busy  out  1  command active or beat pending

## Operation
- FSM: IDLE, RUN. cmd_rdy = (state==IDLE).
- IDLE: cmd_val&&cmd_rdy with cmd_len!=0 -> RUN; lane <= cmd_ofs (cmd_ofs >= BEC taken as 0), rem <= cmd_len. cmd_len==0: command consumed, no beats, stay IDLE.
- RUN: ec = min(BEC - lane, rem); src_ofs = lane, src_ec = ec, both from registers only (no path from src_val). IDLE: src_ofs=0, src_ec=0.
- src_rdy = (state==RUN) && (!bus_val || bus_rdy).
- Load on src_val&&src_rdy: bus_val<=1; bus_strb[i]<=1 for lane <= i < lane+ec; bus_data<=src_b (lane masking per Configuration); bus_last<=(rem==ec); rem<=rem-ec; lane<=0; if rem==ec -> IDLE.
- bus_val&&bus_rdy without load: bus_val<=0; data/strb/last hold their values.
- busy = (state!=IDLE) || bus_val.
- rem arithmetic in LENW bits; ec compare done in LENW bits, ec <= BEC by construction; lane+ec <= BEC always.

## Timing
- Reset values: bus_val 0, bus_data 0, bus_strb 0, bus_last 0, src_ofs 0, src_ec 0, src_rdy 0, cmd_rdy 1, busy 0; state IDLE, rem 0, lane 0.
- rst mid-transfer: all state cleared immediately; pending beat and command dropped; aligner re-init is caller's responsibility.
- Command accepted cycle N -> earliest src pop N+1 -> bus_val N+2.
- Steady state: one beat per cycle while src_val and bus_rdy high.
- bus_val held with bus_rdy low: bus_data/strb/last stable, src_rdy 0.
- Simultaneous drain and load in one cycle permitted (no bubble).
- Between commands: next command accepted the cycle after its predecessor's last pop; exactly one bus_val-low cycle between transfers when bus_rdy stays high.

## Configuration
- RM_WSTRB_ZERO_FILL_EN defined: bus_data lanes with bus_strb=0 forced to zero on load.
- Undefined: bus_data = src_b unmodified on all lanes (non-strobed lanes carry whatever the aligner presents).

## Test plan
- BEC=16, cmd_ofs=5, cmd_len=40, src_val=1, bus_rdy=1 -> 3 beats: strb 0xFFE0/0xFFFF/0x1FFF, src_ec 11/16/13, src_ofs 5/0/0, bus_last only on beat 3; with RM_WSTRB_ZERO_FILL_EN lanes 0-4 of beat 1 and 13-15 of beat 3 read 0.
- cmd_ofs=3, cmd_len=4 -> single beat strb 0x0078, bus_last=1, src_ec=4, back to IDLE, cmd_rdy=1 next cycle.
- cmd_len=40, bus_rdy low 5 cycles after beat 1 -> beat 1 held stable, src_rdy=0 throughout, no pop; resume yields identical 3-beat sequence.
- Back-to-back cmds (ofs 0, len 16) then (ofs 15, len 1), bus_rdy=1 -> strb 0xFFFF last, one bus_val-low cycle, strb 0x8000 last.
- cmd_len=0 -> no src pop, no bus_val, cmd_rdy stays 1, busy stays 0.
- rst pulsed after beat 1 of a 40-element transfer -> all outputs at reset values same cycle; after release, cmd (ofs 0, len 16) yields one beat strb 0xFFFF last.
